freq_gate_counter: RTL

Measurement front end of the frequency counter. It counts rising edges of an external asynchronous signal over a fixed gate window of clock cycles. At the end of each window it latches the result as a 27-bit binary count. That count feeds the bin_to_bcd converter directly, which expands it to eight BCD digits for display.

---
 rtl/freq_gate_counter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/freq_gate_counter.sv
// freq_gate_counter
// Measurement front end of the frequency counter. Rising edges of the
// asynchronous input sig_in are counted over a window of GATE_CYCLES clocks.
// At the end of each window the count is latched onto count_out together with
// a one-cycle valid pulse. count_out feeds the bin_to_bcd converter.
//
// The count saturates at MAX_COUNT, and overflow flags a window that lost edges
// to saturation. Every window is followed by one LATCH cycle in which edges
// are not counted.
//
// Optional build macro DEGLITCH_EN: an edge is accepted only after two low
// samples followed by two high samples. This rejects pulses and gaps shorter
// than two clocks and adds one clock of latency.

module freq_gate_counter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int MAX_COUNT   = 99999999,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             overflow,
  output logic             gate_active
);

  localparam int TMR_W = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_COUNT);
  localparam logic [TMR_W-1:0] LAST_T = TMR_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state;
  logic             sync_p0;
  logic             sync_p1;
  logic             sync_p2;
`ifdef DEGLITCH_EN
  logic             sync_p3;
  logic             sync_p4;
`endif
  logic             rise;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat;
  logic             sat_nxt;
  logic [TMR_W-1:0] timer;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             inc);
    if (inc && (c != MAX_C)) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  // True when an edge arrives but the counter is already at the ceiling.
  function automatic logic sat_hit(input logic [CNT_W-1:0] c,
                                   input logic             inc);
    return inc && (c == MAX_C);
  endfunction

  // Stage p0/p1: two-flop synchronizer. Stage p2 and beyond: edge history.
`ifdef DEGLITCH_EN
  // Synchronizer plus four-sample history, so that a qualified edge can be detected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      sync_p3 <= 1'b0;
      sync_p4 <= 1'b0;
    end else begin
      sync_p0 <= sig_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      sync_p3 <= sync_p2;
      sync_p4 <= sync_p3;
    end
  end

  // Accept the edge only when two low samples precede two high samples.
  assign rise = sync_p1 & sync_p2 & ~sync_p3 & ~sync_p4;
`else
  // Synchronizer plus one history flop for the plain edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= sig_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Every synchronized 0->1 transition counts.
  assign rise = sync_p1 & ~sync_p2;
`endif

  // Count value and saturation flag after the current cycle's edge, if any.
  assign cnt_nxt = sat_inc(edge_cnt, rise);
  assign sat_nxt = sat | sat_hit(edge_cnt, rise);

  // Gate FSM: times the window, accumulates edges, and latches the result.
  // The outputs are registered. They are loaded on the transition into LATCH,
  // so valid and the new count_out appear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      edge_cnt    <= '0;
      sat         <= 1'b0;
      count_out   <= '0;
      overflow    <= 1'b0;
      valid       <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          timer    <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (enable) begin
            state       <= GATE;
            gate_active <= 1'b1;
          end
        end
        GATE: begin
          // The final gate cycle's edge is included through cnt_nxt/sat_nxt.
          edge_cnt <= cnt_nxt;
          sat      <= sat_nxt;
          if (timer == LAST_T) begin
            state       <= LATCH;
            gate_active <= 1'b0;
            timer       <= '0;
            count_out   <= cnt_nxt;
            overflow    <= sat_nxt;
            valid       <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        LATCH: begin
          // Dead cycle: any edge seen now is dropped along with the old count.
          timer    <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (enable) begin
            state       <= GATE;
            gate_active <= 1'b1;
          end else begin
            state       <= IDLE;
            gate_active <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          gate_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
